// File: rtl/mcpu_loader_pkg.sv
// -----------------------------------------------------------------------------
// mcpu_loader_pkg
// Shared definitions for the MCPU program loader/dumper: FSM state encoding,
// transfer-mode constants and the default word/address widths used by MCPU.
// -----------------------------------------------------------------------------
package mcpu_loader_pkg;

    // Default geometry, shared with the MCPU core and its RAM.
    localparam int DEF_WORD_SIZE = 16;
    localparam int DEF_ADDR_SIZE = 8;

    // Transfer direction, sampled together with start.
    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_DUMP = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_DUMP_ADDR = 3'd2,
        ST_DUMP_CAP  = 3'd3,
        ST_DUMP_OUT  = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

endpackage : mcpu_loader_pkg

// File: rtl/mcpu_loader_cksum.sv
// -----------------------------------------------------------------------------
// mcpu_loader_cksum
// XOR accumulator for the words moved by the loader. Only instantiated when
// MCPU_LOADER_CKSUM_EN is defined.
//
// Ports:
//   i_clk     clock
//   i_reset   synchronous active-low reset (clears the accumulator)
//   i_clear   clear the accumulator (has priority over i_en)
//   i_en      fold i_data into the accumulator this cycle
//   i_data    word to accumulate
//   o_cksum   current accumulator value
// -----------------------------------------------------------------------------
module mcpu_loader_cksum #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_cksum
);

    logic [WIDTH-1:0] r_acc;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_data;
        end
    end

    assign o_cksum = r_acc;

endmodule : mcpu_loader_cksum

// File: rtl/mcpu_prog_loader.sv
// -----------------------------------------------------------------------------
// mcpu_prog_loader
// Program loader/dumper for the MCPU single-port RAM.
//   LOAD: writes an incoming word stream into RAM starting at a base address.
//   DUMP: reads a RAM window back out as a word stream.
// The CPU is held in reset until the first LOAD completes, and frozen while
// any transfer is in progress.
//
// Optional feature: define MCPU_LOADER_CKSUM_EN to add o_cksum, the XOR of
// every word written (LOAD) or handed off (DUMP) since the last start.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-low reset
//   i_start, i_mode         one-cycle request and direction (0 LOAD, 1 DUMP)
//   i_base_addr, i_length   first RAM address, word count (0..RAM_SIZE)
//   i_s_data/valid, o_s_ready   load stream
//   o_m_data/valid, i_m_ready   dump stream
//   o_mem_addr/wdata/we, i_mem_rdata   RAM port (read data one cycle late)
//   o_cpu_reset             active-high reset to MCPU
//   o_busy, o_done          not idle / one-cycle completion pulse
//   o_cksum                 (MCPU_LOADER_CKSUM_EN only) running XOR
// -----------------------------------------------------------------------------
module mcpu_prog_loader
    import mcpu_loader_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_mode,
    input  logic [ADDR_SIZE-1:0] i_base_addr,
    input  logic [ADDR_SIZE:0]   i_length,
    input  logic [WORD_SIZE-1:0] i_s_data,
    input  logic                 i_s_valid,
    output logic                 o_s_ready,
    output logic [WORD_SIZE-1:0] o_m_data,
    output logic                 o_m_valid,
    input  logic                 i_m_ready,
    output logic [ADDR_SIZE-1:0] o_mem_addr,
    output logic [WORD_SIZE-1:0] o_mem_wdata,
    output logic                 o_mem_we,
    input  logic [WORD_SIZE-1:0] i_mem_rdata,
    output logic                 o_cpu_reset,
    output logic                 o_busy,
    output logic                 o_done
`ifdef MCPU_LOADER_CKSUM_EN
    ,
    output logic [WORD_SIZE-1:0] o_cksum
`endif
);

    localparam int                 RAM_SIZE = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] LEN_MAX  = (ADDR_SIZE + 1)'(RAM_SIZE);
    localparam logic [ADDR_SIZE:0] REM_ONE  = (ADDR_SIZE + 1)'(1);
    localparam logic [ADDR_SIZE:0] LEN_ZERO = '0;
    localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ADDR_SIZE-1:0]   r_ptr;
    logic [ADDR_SIZE:0]     r_rem;
    logic [WORD_SIZE-1:0]   r_m_data;
    logic                   r_mode;
    logic                   r_loaded;

    logic                   w_start_ok;
    logic                   w_load_acc;
    logic                   w_dump_acc;
    logic                   w_last;

    assign w_last = (r_rem == REM_ONE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and combinational outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_start_ok   = 1'b0;
        w_load_acc   = 1'b0;
        w_dump_acc   = 1'b0;
        o_s_ready    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_wdata  = '0;
        o_m_valid    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_start_ok = 1'b1;
                    if (i_length == LEN_ZERO) begin
                        w_next_state = ST_DONE;
                    end else if (i_mode == MODE_DUMP) begin
                        w_next_state = ST_DUMP_ADDR;
                    end else begin
                        w_next_state = ST_LOAD;
                    end
                end
            end

            // Handshakes are masked while reset is asserted so that an abort
            // never commits the word that was in flight.
            ST_LOAD: begin
                o_s_ready   = i_reset;
                o_mem_wdata = i_s_data;
                if (i_s_valid && i_reset) begin
                    w_load_acc = 1'b1;
                    o_mem_we   = 1'b1;
                    if (w_last) begin
                        w_next_state = ST_DONE;
                    end
                end
            end

            ST_DUMP_ADDR: begin
                w_next_state = ST_DUMP_CAP;
            end

            // RAM read data for the address driven last cycle is valid now.
            ST_DUMP_CAP: begin
                w_next_state = ST_DUMP_OUT;
            end

            ST_DUMP_OUT: begin
                o_m_valid = i_reset;
                if (i_m_ready && i_reset) begin
                    w_dump_acc   = 1'b1;
                    w_next_state = w_last ? ST_DONE : ST_DUMP_ADDR;
                end
            end

            ST_DONE: begin
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: pointer, remaining count, dump holding register, loaded flag
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_ptr    <= '0;
            r_rem    <= '0;
            r_m_data <= '0;
            r_mode   <= MODE_LOAD;
            r_loaded <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_ptr  <= i_base_addr;
                r_rem  <= (i_length > LEN_MAX) ? LEN_MAX : i_length;
                r_mode <= i_mode;
            end
            // Pointer is exactly ADDR_SIZE bits wide, so it wraps modulo RAM_SIZE.
            if (w_load_acc || w_dump_acc) begin
                r_ptr <= r_ptr + PTR_ONE;
                r_rem <= r_rem - REM_ONE;
            end
            if (r_state == ST_DUMP_CAP) begin
                r_m_data <= i_mem_rdata;
            end
            if (r_state == ST_DONE && r_mode == MODE_LOAD) begin
                r_loaded <= 1'b1;
            end
        end
    end

    assign o_mem_addr  = r_ptr;
    assign o_m_data    = r_m_data;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_cpu_reset = !r_loaded || o_busy;

`ifdef MCPU_LOADER_CKSUM_EN
    logic [WORD_SIZE-1:0] w_ck_data;

    assign w_ck_data = w_load_acc ? i_s_data : r_m_data;

    mcpu_loader_cksum #(
        .WIDTH (WORD_SIZE)
    ) u_cksum (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_start_ok),
        .i_en    (w_load_acc || w_dump_acc),
        .i_data  (w_ck_data),
        .o_cksum (o_cksum)
    );
`endif

endmodule : mcpu_prog_loader

// File: tb/tb_mcpu_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_mcpu_prog_loader
// Self-checking bench for mcpu_prog_loader: a table of LOAD/DUMP transfers
// applied in a loop, with a write/handoff scoreboard, plus hand-written
// sequences for reset, start-while-busy and reset-abort corner cases.
// -----------------------------------------------------------------------------
module tb_mcpu_prog_loader;
    import mcpu_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [7:0]  base_addr;
    logic [8:0]  length;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
`ifdef MCPU_LOADER_CKSUM_EN
    logic [15:0] cksum;
`endif

    always #5 clk = ~clk;

    mcpu_prog_loader #(
        .WORD_SIZE (16),
        .ADDR_SIZE (8)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset_n),
        .i_start     (start),
        .i_mode      (mode),
        .i_base_addr (base_addr),
        .i_length    (length),
        .i_s_data    (s_data),
        .i_s_valid   (s_valid),
        .o_s_ready   (s_ready),
        .o_m_data    (m_data),
        .o_m_valid   (m_valid),
        .i_m_ready   (m_ready),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_we    (mem_we),
        .i_mem_rdata (mem_rdata),
        .o_cpu_reset (cpu_reset),
        .o_busy      (busy),
        .o_done      (done)
`ifdef MCPU_LOADER_CKSUM_EN
        ,
        .o_cksum     (cksum)
`endif
    );

    // Single-port RAM with registered read data.
    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- scoreboard
    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } xfer_t;

    xfer_t wr_q[$];
    xfer_t rd_q[$];
    int    we_count = 0;

    function automatic xfer_t mkx(input logic [7:0] a, input logic [15:0] d);
        xfer_t x;
        x.addr = a;
        x.data = d;
        return x;
    endfunction

    always @(negedge clk) begin
        xfer_t e;
        if (mem_we) begin
            we_count++;
            if (wr_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = wr_q.pop_front();
                check("write_addr", {24'h0, mem_addr}, {24'h0, e.addr});
                check("write_data", {16'h0, mem_wdata}, {16'h0, e.data});
            end
        end
        if (m_valid && m_ready) begin
            if (rd_q.size() == 0) begin
                check("unexpected_handoff", 1, 0);
            end else begin
                e = rd_q.pop_front();
                check("dump_data", {16'h0, m_data}, {16'h0, e.data});
                check("dump_addr", {24'h0, mem_addr}, {24'h0, e.addr});
            end
        end
    end

    // ---------------------------------------------------------------- vectors
    typedef struct packed {
        logic            mode;
        logic [7:0]      base;
        logic [8:0]      len;
        logic            toggle;
        logic [3:0]      stall;
        logic [3:0][15:0] w;
        logic [8:0]      exp_n;   // words that must actually move
    } vec_t;

    function automatic vec_t mkv(input logic m, input logic [7:0] b, input logic [8:0] l,
                                 input logic t, input logic [3:0] s,
                                 input logic [15:0] w0, input logic [15:0] w1,
                                 input logic [15:0] w2, input logic [15:0] w3,
                                 input logic [8:0] n);
        vec_t v;
        v.mode = m;  v.base = b;  v.len = l;  v.toggle = t;  v.stall = s;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.exp_n = n;
        return v;
    endfunction

    // Long transfers use a generated pattern instead of the four table words.
    function automatic logic [15:0] word_at(input vec_t v, input int i);
        if (v.len > 9'd4) return 16'(i * 7 + 3);
        return v.w[i];
    endfunction

    vec_t vecs[7];

    // ---------------------------------------------------------------- LOAD
    task automatic run_load(input vec_t v);
        int          n;
        int          idx;
        int          cyc;
        int          we0;
        logic [15:0] ck;
        bit          acc;
        n  = int'(v.exp_n);
        ck = '0;
        @(posedge clk); #1;
        start = 1'b1; mode = v.mode; base_addr = v.base; length = v.len;
        for (int i = 0; i < n; i++) begin
            wr_q.push_back(mkx(v.base + 8'(i), word_at(v, i)));
            ck = ck ^ word_at(v, i);
        end
        we0 = we_count;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 1000) begin
            s_valid = v.toggle ? (cyc % 2 == 0) : 1'b1;
            s_data  = s_valid ? word_at(v, idx) : 16'hDEAD;
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        s_valid = 1'b0;
        s_data  = '0;
        check("load_words_accepted", idx, n);
        check("load_cycles", cyc, v.toggle ? 2 * n - 1 : n);
        @(negedge clk);
        check("load_done_rise", {31'h0, done}, 1);
        check("load_cpu_reset_in_done", {31'h0, cpu_reset}, 1);
        check("load_we_pulses", we_count - we0, n);
        @(posedge clk); #1;
        @(negedge clk);
        check("load_done_drop", {31'h0, done}, 0);
        check("load_idle", {31'h0, busy}, 0);
        check("load_cpu_released", {31'h0, cpu_reset}, 0);
        check("load_queue_empty", wr_q.size(), 0);
`ifdef MCPU_LOADER_CKSUM_EN
        check("load_cksum", {16'h0, cksum}, {16'h0, ck});
`endif
    endtask

    // ---------------------------------------------------------------- DUMP
    task automatic run_dump(input vec_t v);
        int          n;
        int          t;
        int          seen;
        int          last_t;
        int          stall_left;
        logic [15:0] hold;
        logic [15:0] ck;
        bit          have_hold;
        bit          got_done;
        n  = int'(v.exp_n);
        ck = '0;
        @(posedge clk); #1;
        start = 1'b1; mode = v.mode; base_addr = v.base; length = v.len;
        for (int i = 0; i < n; i++) begin
            rd_q.push_back(mkx(v.base + 8'(i), word_at(v, i)));
            ck = ck ^ word_at(v, i);
        end
        stall_left = int'(v.stall);
        m_ready    = (v.stall == 4'd0);
        t = 0; seen = 0; last_t = 0; have_hold = 1'b0; got_done = 1'b0; hold = '0;
        while (!got_done && t < 400) begin
            @(negedge clk);
            t++;
            if (m_valid) begin
                if (seen >= n) check("dump_extra_valid", 1, 0);
                if (!have_hold) begin
                    if (seen == 0) begin
                        check("dump_first_valid_latency", t, 4);
                        check("cpu_reset_during_dump", {31'h0, cpu_reset}, 1);
                    end else begin
                        check("dump_word_gap", t - last_t, 3);
                    end
                    hold      = m_data;
                    have_hold = 1'b1;
                end else begin
                    check("dump_data_stable", {16'h0, m_data}, {16'h0, hold});
                end
                if (m_ready) begin
                    seen++;
                    last_t    = t;
                    have_hold = 1'b0;
                end else if (stall_left > 0) begin
                    stall_left--;
                end
            end
            if (done) begin
                got_done = 1'b1;
                check("dump_done_time", t, (n == 0) ? 2 : last_t + 1);
            end
            @(posedge clk); #1;
            start   = 1'b0;
            m_ready = (stall_left == 0);
        end
        m_ready = 1'b0;
        if (!got_done) check("dump_timeout", 0, 1);
        check("dump_words", seen, n);
        check("dump_queue_empty", rd_q.size(), 0);
        @(negedge clk);
        check("dump_done_drop", {31'h0, done}, 0);
        check("dump_idle", {31'h0, busy}, 0);
        check("dump_cpu_released", {31'h0, cpu_reset}, 0);
`ifdef MCPU_LOADER_CKSUM_EN
        check("dump_cksum", {16'h0, cksum}, {16'h0, ck});
`endif
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        int we0;
        bit got;

        //              mode       base   len     tgl   stall  w0        w1        w2        w3        n
        vecs[0] = mkv(MODE_LOAD, 8'h00, 9'd2,   1'b0, 4'd0, 16'h1030, 16'h110C, 16'h0000, 16'h0000, 9'd2);
        vecs[1] = mkv(MODE_LOAD, 8'hFE, 9'd4,   1'b1, 4'd0, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 9'd4);
        vecs[2] = mkv(MODE_LOAD, 8'd100, 9'd2,  1'b0, 4'd0, 16'd48,   16'd12,   16'h0000, 16'h0000, 9'd2);
        vecs[3] = mkv(MODE_DUMP, 8'd100, 9'd2,  1'b0, 4'd5, 16'd48,   16'd12,   16'h0000, 16'h0000, 9'd2);
        vecs[4] = mkv(MODE_DUMP, 8'hFF, 9'd3,   1'b0, 4'd0, 16'hA002, 16'hA003, 16'hA004, 16'h0000, 9'd3);
        vecs[5] = mkv(MODE_DUMP, 8'h20, 9'd0,   1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 9'd0);
        vecs[6] = mkv(MODE_LOAD, 8'h00, 9'd511, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 9'd256);

        reset_n = 1'b0; start = 1'b0; mode = MODE_LOAD; base_addr = '0; length = '0;
        s_data = 16'hFFFF; s_valid = 1'b1; m_ready = 1'b0;

        // Reset held three cycles with stream activity present.
        repeat (3) @(negedge clk);
        check("rst_s_ready",   {31'h0, s_ready},   0);
        check("rst_m_valid",   {31'h0, m_valid},   0);
        check("rst_m_data",    {16'h0, m_data},    0);
        check("rst_mem_we",    {31'h0, mem_we},    0);
        check("rst_mem_addr",  {24'h0, mem_addr},  0);
        check("rst_mem_wdata", {16'h0, mem_wdata}, 0);
        check("rst_busy",      {31'h0, busy},      0);
        check("rst_done",      {31'h0, done},      0);
        check("rst_cpu_reset", {31'h0, cpu_reset}, 1);
`ifdef MCPU_LOADER_CKSUM_EN
        check("rst_cksum",     {16'h0, cksum},     0);
`endif
        @(posedge clk); #1;
        reset_n = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (2) @(negedge clk);
        check("idle_cpu_reset_before_load", {31'h0, cpu_reset}, 1);
        check("idle_busy", {31'h0, busy}, 0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].mode == MODE_LOAD) run_load(vecs[i]);
            else                           run_dump(vecs[i]);
        end

        // Start held high through a whole DUMP: mid-transfer and DONE-cycle
        // requests must both be ignored. mem[100] holds 100*7+3 after the fill.
        @(posedge clk); #1;
        start = 1'b1; mode = MODE_DUMP; base_addr = 8'd100; length = 9'd1; m_ready = 1'b1;
        rd_q.push_back(mkx(8'd100, 16'h02BF));
        @(posedge clk); #1;
        mode = MODE_LOAD; base_addr = 8'h00; length = 9'd5;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("busy_start_done_seen", {31'h0, got}, 1);
        @(posedge clk); #1;
        start = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", {31'h0, busy}, 0);
        check("busy_start_queue_empty", rd_q.size(), 0);

        // Reset mid-LOAD after 3 of 8 words, with a start and a valid word
        // presented during the reset cycle.
        @(posedge clk); #1;
        start = 1'b1; mode = MODE_LOAD; base_addr = 8'h10; length = 9'd8;
        for (int i = 0; i < 3; i++) wr_q.push_back(mkx(8'h10 + 8'(i), 16'h5A00 + 16'(i)));
        we0 = we_count;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 16'h5A00 + 16'(i);
            @(posedge clk); #1;
        end
        reset_n = 1'b0; s_valid = 1'b1; s_data = 16'h5A03;
        start = 1'b1; mode = MODE_DUMP; base_addr = 8'h00; length = 9'd2;
        @(negedge clk);
        check("abort_no_inflight_write", {31'h0, mem_we}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        @(negedge clk);
        check("abort_idle", {31'h0, busy}, 0);
        check("abort_loaded_cleared", {31'h0, cpu_reset}, 1);
        check("abort_s_ready", {31'h0, s_ready}, 0);
        check("abort_done", {31'h0, done}, 0);
        check("abort_writes", we_count - we0, 3);
        check("abort_queue_empty", wr_q.size(), 0);
`ifdef MCPU_LOADER_CKSUM_EN
        check("abort_cksum", {16'h0, cksum}, 0);
`endif
        @(negedge clk);
        check("abort_start_ignored", {31'h0, busy}, 0);
        check("abort_no_m_valid", {31'h0, m_valid}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_mcpu_prog_loader
